// File: rtl/mips_mc_pkg.sv
// Shared constants for the multi-cycle MIPS control unit:
// state codes, opcodes, mux encodings, class bits.
package mips_mc_pkg;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  // I-ALU occupies 0x08..0x0F
  localparam logic [2:0] OP_IALU_HI = 3'b001;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUB_RT      = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

  typedef enum int {
    CLS_R    = 0,
    CLS_IALU = 1,
    CLS_LW   = 2,
    CLS_SW   = 3,
    CLS_BEQ  = 4,
    CLS_BNE  = 5,
    CLS_J    = 6,
    CLS_ILL  = 7
  } cls_idx_e;

  typedef logic [7:0] cls_t;

  typedef struct packed {
    logic       pc_wr;
    logic [1:0] pc_src;
    logic       ir_wr;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       alu_a;
    logic [1:0] alu_b;
    logic       reg_wr;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;
  } ctl_t;

endpackage

// File: rtl/mc_instr_class.sv
// Opcode to one-hot instruction class.
// Ports: op_i (opcode), cls_o (one-hot class, CLS_* bits).
module mc_instr_class
  import mips_mc_pkg::*;
(
  input  logic [5:0] op_i,
  output cls_t       cls_o
);

  always_comb begin
    cls_o = '0;
    unique case (1'b1)
      (op_i == OP_RTYPE):        cls_o[CLS_R]    = 1'b1;
      (op_i == OP_J):            cls_o[CLS_J]    = 1'b1;
      (op_i == OP_BEQ):          cls_o[CLS_BEQ]  = 1'b1;
      (op_i == OP_BNE):          cls_o[CLS_BNE]  = 1'b1;
      (op_i[5:3] == OP_IALU_HI): cls_o[CLS_IALU] = 1'b1;
      (op_i == OP_LW):           cls_o[CLS_LW]   = 1'b1;
      (op_i == OP_SW):           cls_o[CLS_SW]   = 1'b1;
      default:                   cls_o[CLS_ILL]  = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) with
// combinational strobes and a retired-instruction counter.
// Ports: clk, reset (async active-low), op/funct/z/mem_rdy in;
// PC, IR, memory, ALU-mux, regfile strobes, state, illegal,
// retired count out.
// MC_CTRL_MEM_WAIT_EN: FETCH/MEM wait for mem_rdy; otherwise
// each memory state is a single cycle and mem_rdy is ignored.
module mc_control
  import mips_mc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op_mc_ctl_i,
  input  logic [5:0]  funct_mc_ctl_i,
  input  logic        z_mc_ctl_i,
  input  logic        mem_rdy_mc_ctl_i,
  output logic        pc_wr_mc_ctl_o,
  output logic [1:0]  pc_src_mc_ctl_o,
  output logic        ir_wr_mc_ctl_o,
  output logic        iord_mc_ctl_o,
  output logic        mem_rd_mc_ctl_o,
  output logic        mem_wr_mc_ctl_o,
  output logic        alu_src_a_mc_ctl_o,
  output logic [1:0]  alu_src_b_mc_ctl_o,
  output logic        reg_wr_mc_ctl_o,
  output logic        reg_dst_mc_ctl_o,
  output logic        mem_to_reg_mc_ctl_o,
  output logic [2:0]  state_mc_ctl_o,
  output logic        illegal_mc_ctl_o,
  output logic [31:0] retired_mc_ctl_o
);

  logic [2:0]  state_q, state_d;
  logic [31:0] retired_q;
  logic        ret_inc;
  logic        mem_go;
  cls_t        cls;
  ctl_t        ctl;

  // funct is decoded by the ALU control, not here
  logic unused_ok;
  assign unused_ok = ^{funct_mc_ctl_i, mem_rdy_mc_ctl_i};

`ifdef MC_CTRL_MEM_WAIT_EN
  assign mem_go = mem_rdy_mc_ctl_i;
`else
  assign mem_go = 1'b1;
`endif

  mc_instr_class u_cls (
    .op_i  (op_mc_ctl_i),
    .cls_o (cls)
  );

  always_comb begin
    ctl     = '0;
    state_d = ST_FETCH;
    ret_inc = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ctl.mem_rd = 1'b1;
        ctl.alu_b  = ALUB_FOUR;
        if (mem_go) begin
          ctl.ir_wr  = 1'b1;
          ctl.pc_wr  = 1'b1;
          ctl.pc_src = PC_SRC_ALU;
          state_d    = ST_DECODE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        ctl.alu_b = ALUB_IMM_SH2;
        if (cls[CLS_J]) begin
          ctl.pc_wr  = 1'b1;
          ctl.pc_src = PC_SRC_JUMP;
          ret_inc    = 1'b1;
        end else if (cls[CLS_ILL]) begin
          ctl.illegal = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        ctl.alu_a = 1'b1;
        unique case (1'b1)
          cls[CLS_R]: begin
            ctl.alu_b = ALUB_RT;
            state_d   = ST_WB;
          end
          cls[CLS_IALU]: begin
            ctl.alu_b = ALUB_IMM;
            state_d   = ST_WB;
          end
          cls[CLS_LW], cls[CLS_SW]: begin
            ctl.alu_b = ALUB_IMM;
            state_d   = ST_MEM;
          end
          cls[CLS_BEQ], cls[CLS_BNE]: begin
            ctl.alu_b  = ALUB_RT;
            ctl.pc_src = PC_SRC_ALUOUT;
            ctl.pc_wr  = cls[CLS_BEQ] ? z_mc_ctl_i
                                      : ~z_mc_ctl_i;
            ret_inc    = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        ctl.iord   = 1'b1;
        ctl.mem_rd = cls[CLS_LW];
        ctl.mem_wr = cls[CLS_SW];
        if (mem_go) begin
          state_d = cls[CLS_LW] ? ST_WB : ST_FETCH;
          ret_inc = ~cls[CLS_LW];
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB: begin
        ctl.reg_wr     = 1'b1;
        ctl.reg_dst    = cls[CLS_R];
        ctl.mem_to_reg = cls[CLS_LW];
        ret_inc        = 1'b1;
      end
      default: ;
    endcase
    // outputs are forced quiet while reset is held
    if (!reset) begin
      ctl = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (ret_inc) begin
        retired_q <= retired_q + 32'd1;
      end
    end
  end

  assign pc_wr_mc_ctl_o      = ctl.pc_wr;
  assign pc_src_mc_ctl_o     = ctl.pc_src;
  assign ir_wr_mc_ctl_o      = ctl.ir_wr;
  assign iord_mc_ctl_o       = ctl.iord;
  assign mem_rd_mc_ctl_o     = ctl.mem_rd;
  assign mem_wr_mc_ctl_o     = ctl.mem_wr;
  assign alu_src_a_mc_ctl_o  = ctl.alu_a;
  assign alu_src_b_mc_ctl_o  = ctl.alu_b;
  assign reg_wr_mc_ctl_o     = ctl.reg_wr;
  assign reg_dst_mc_ctl_o    = ctl.reg_dst;
  assign mem_to_reg_mc_ctl_o = ctl.mem_to_reg;
  assign illegal_mc_ctl_o    = ctl.illegal;
  assign state_mc_ctl_o      = state_q;
  assign retired_mc_ctl_o    = retired_q;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: per-cycle trace table
// plus latency, reset-abort and memory-wait sequences.
module tb_mc_control;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  op = 6'h00;
  logic [5:0]  funct = 6'h20;
  logic        z = 1'b0;
  logic        rdy = 1'b0;
  logic        pc_wr, ir_wr, iord, mem_rd, mem_wr, alu_a;
  logic        reg_wr, reg_dst, m2r, ill;
  logic [1:0]  pc_src, alu_b;
  logic [2:0]  state;
  logic [31:0] retired;
  logic [13:0] ctl_w;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mc_control dut (
    .clk                 (clk),
    .reset               (reset),
    .op_mc_ctl_i         (op),
    .funct_mc_ctl_i      (funct),
    .z_mc_ctl_i          (z),
    .mem_rdy_mc_ctl_i    (rdy),
    .pc_wr_mc_ctl_o      (pc_wr),
    .pc_src_mc_ctl_o     (pc_src),
    .ir_wr_mc_ctl_o      (ir_wr),
    .iord_mc_ctl_o       (iord),
    .mem_rd_mc_ctl_o     (mem_rd),
    .mem_wr_mc_ctl_o     (mem_wr),
    .alu_src_a_mc_ctl_o  (alu_a),
    .alu_src_b_mc_ctl_o  (alu_b),
    .reg_wr_mc_ctl_o     (reg_wr),
    .reg_dst_mc_ctl_o    (reg_dst),
    .mem_to_reg_mc_ctl_o (m2r),
    .state_mc_ctl_o      (state),
    .illegal_mc_ctl_o    (ill),
    .retired_mc_ctl_o    (retired)
  );

  // pcw pcs irw iord mrd mwr a b rw rd m2r ill
  assign ctl_w = {pc_wr, pc_src, ir_wr, iord, mem_rd,
                  mem_wr, alu_a, alu_b, reg_wr, reg_dst,
                  m2r, ill};

  localparam logic [13:0] C0  = 14'b0_00_0_0_0_0_0_00_0_0_0_0;
  localparam logic [13:0] CF  = 14'b1_00_1_0_1_0_0_01_0_0_0_0;
  localparam logic [13:0] CD  = 14'b0_00_0_0_0_0_0_11_0_0_0_0;
  localparam logic [13:0] CER = 14'b0_00_0_0_0_0_1_00_0_0_0_0;
  localparam logic [13:0] CEI = 14'b0_00_0_0_0_0_1_10_0_0_0_0;
  localparam logic [13:0] CML = 14'b0_00_0_1_1_0_0_00_0_0_0_0;
  localparam logic [13:0] CMS = 14'b0_00_0_1_0_1_0_00_0_0_0_0;
  localparam logic [13:0] CWR = 14'b0_00_0_0_0_0_0_00_1_1_0_0;
  localparam logic [13:0] CWI = 14'b0_00_0_0_0_0_0_00_1_0_0_0;
  localparam logic [13:0] CWL = 14'b0_00_0_0_0_0_0_00_1_0_1_0;
  localparam logic [13:0] CBT = 14'b1_01_0_0_0_0_1_00_0_0_0_0;
  localparam logic [13:0] CBN = 14'b0_01_0_0_0_0_1_00_0_0_0_0;
  localparam logic [13:0] CJ  = 14'b1_10_0_0_0_0_0_11_0_0_0_0;
  localparam logic [13:0] CIL = 14'b0_00_0_0_0_0_0_11_0_0_0_1;

  typedef struct {
    logic [5:0]  op;
    logic        z;
    logic [2:0]  st;
    logic [13:0] ctl;
    logic [31:0] ret;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [5:0] o, input logic zz,
                     input int st, input logic [13:0] c,
                     input int ret);
    vec_t v;
    v.op  = o;
    v.z   = zz;
    v.st  = st[2:0];
    v.ctl = c;
    v.ret = ret;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Runs one instruction from FETCH back to FETCH. In FETCH and
  // MEM, mem_rdy stays low for dly cycles then goes high.
  task automatic run_instr(input logic [5:0] o, input logic zz,
                           input int dly, output int cyc,
                           output int nwr, output int nld);
    int k;
    logic [2:0] prev;
    bit done;
    k = 0;
    done = 0;
    cyc = 0;
    nwr = 0;
    nld = 0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      op = o;
      z = zz;
      rdy = (k >= dly);
      #1;
      if (mem_wr) nwr++;
      if (reg_wr && m2r) nld++;
      prev = state;
      @(posedge clk);
      #1;
      cyc++;
      if (state != prev) k = 0;
      else k++;
      if (prev != 3'd0 && state == 3'd0) done = 1;
    end
    if (!done) chk("instr_timeout", 32'd0, 32'd1);
  endtask

  int cyc, nwr, nld;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset held with memory ready and a legal opcode
    rdy = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ctl", 32'(ctl_w), 32'(C0));
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_retired", retired, 32'd0);

    // op, z, state, strobes, retired (state before the edge)
    add(6'h00, 1'b0, 0, CF,  0);
    add(6'h00, 1'b0, 1, CD,  0);
    add(6'h00, 1'b0, 2, CER, 0);
    add(6'h00, 1'b0, 4, CWR, 0);
    add(6'h23, 1'b0, 0, CF,  1);
    add(6'h23, 1'b0, 1, CD,  1);
    add(6'h23, 1'b0, 2, CEI, 1);
    add(6'h23, 1'b0, 3, CML, 1);
    add(6'h23, 1'b0, 4, CWL, 1);
    add(6'h2B, 1'b0, 0, CF,  2);
    add(6'h2B, 1'b0, 1, CD,  2);
    add(6'h2B, 1'b0, 2, CEI, 2);
    add(6'h2B, 1'b0, 3, CMS, 2);
    add(6'h04, 1'b1, 0, CF,  3);
    add(6'h04, 1'b1, 1, CD,  3);
    add(6'h04, 1'b1, 2, CBT, 3);
    add(6'h05, 1'b1, 0, CF,  4);
    add(6'h05, 1'b1, 1, CD,  4);
    add(6'h05, 1'b1, 2, CBN, 4);
    add(6'h04, 1'b0, 0, CF,  5);
    add(6'h04, 1'b0, 1, CD,  5);
    add(6'h04, 1'b0, 2, CBN, 5);
    add(6'h05, 1'b0, 0, CF,  6);
    add(6'h05, 1'b0, 1, CD,  6);
    add(6'h05, 1'b0, 2, CBT, 6);
    add(6'h02, 1'b0, 0, CF,  7);
    add(6'h02, 1'b0, 1, CJ,  7);
    add(6'h3F, 1'b0, 0, CF,  8);
    add(6'h3F, 1'b0, 1, CIL, 8);
    add(6'h08, 1'b0, 0, CF,  8);
    add(6'h08, 1'b0, 1, CD,  8);
    add(6'h08, 1'b0, 2, CEI, 8);
    add(6'h08, 1'b0, 4, CWI, 8);
    add(6'h0F, 1'b0, 0, CF,  9);
    add(6'h0F, 1'b0, 1, CD,  9);
    add(6'h0F, 1'b0, 2, CEI, 9);
    add(6'h0F, 1'b0, 4, CWI, 9);
    add(6'h10, 1'b0, 0, CF,  10);
    add(6'h10, 1'b0, 1, CIL, 10);
    add(6'h07, 1'b0, 0, CF,  10);
    add(6'h07, 1'b0, 1, CIL, 10);
    add(6'h01, 1'b0, 0, CF,  10);
    add(6'h01, 1'b0, 1, CIL, 10);

    foreach (tbl[i]) begin
      @(negedge clk);
      reset = 1'b1;
      op = tbl[i].op;
      z = tbl[i].z;
      rdy = 1'b1;
      #1;
      chk($sformatf("row%0d_state", i), 32'(state),
          32'(tbl[i].st));
      chk($sformatf("row%0d_ctl", i), 32'(ctl_w),
          32'(tbl[i].ctl));
      chk($sformatf("row%0d_retired", i), retired, tbl[i].ret);
    end

    // zero-wait latencies
    run_instr(6'h02, 1'b0, 0, cyc, nwr, nld);
    chk("lat_j", cyc, 2);
    run_instr(6'h04, 1'b1, 0, cyc, nwr, nld);
    chk("lat_beq", cyc, 3);
    run_instr(6'h05, 1'b0, 0, cyc, nwr, nld);
    chk("lat_bne", cyc, 3);
    run_instr(6'h2B, 1'b0, 0, cyc, nwr, nld);
    chk("lat_sw", cyc, 4);
    chk("sw_wr_cycles", nwr, 1);
    run_instr(6'h00, 1'b0, 0, cyc, nwr, nld);
    chk("lat_r", cyc, 4);
    run_instr(6'h0A, 1'b0, 0, cyc, nwr, nld);
    chk("lat_ialu", cyc, 4);
    run_instr(6'h23, 1'b0, 0, cyc, nwr, nld);
    chk("lat_lw", cyc, 5);
    chk("lw_load_wb", nld, 1);
    chk("retired_after_lat", retired, 32'd17);

`ifdef MC_CTRL_MEM_WAIT_EN
    run_instr(6'h23, 1'b0, 3, cyc, nwr, nld);
    chk("lw_wait_cycles", cyc, 11);
    chk("lw_wait_load_wb", nld, 1);
`else
    run_instr(6'h2B, 1'b0, 1000, cyc, nwr, nld);
    chk("sw_nowait_cycles", cyc, 4);
    chk("sw_nowait_wr", nwr, 1);
`endif
    chk("retired_before_abort", retired, 32'd18);

    // reset in the MEM state of a store
    @(negedge clk);
    op = 6'h2B;
    rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("abort_pre_state", 32'(state), 32'd3);
    chk("abort_pre_wr", 32'(mem_wr), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_wr", 32'(mem_wr), 32'd0);
    chk("abort_ctl", 32'(ctl_w), 32'(C0));
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_retired", retired, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post_rst_ctl", 32'(ctl_w), 32'(CF));
    chk("post_rst_state", 32'(state), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
